sine_sample_fetcher: RTL and testbench
======================================

# sine_sample_fetcher

Consumer-side partner of the sine reader. Issues single-cycle `generate_next` requests with a stable `step_size`, waits for the `sample_ready`/`sample` response, and buffers returned samples in a small prefetch FIFO. The codec drains the FIFO one sample per `codec_next_sample` pulse. Sits between the sine reader and the codec interface in the music-player datapath.

## Interface
- `FIFO_DEPTH`, default 4: prefetch buffer depth; power of 2, ≥2.
- `TIMEOUT`, default 8: number of WAIT cycles allowed for `sample_ready` before aborting; ≥3.
- `clk`, in, 1: single system clock; all logic is rising-edge.
- `reset`, in, 1: reset; synchronous, active-high.
- `play_enable`, in, 1: when high, the block may issue new requests.
- `step_size_in`, in, 20: phase increment supplied by the note logic.
- `codec_next_sample`, in, 1: one-cycle pop request from the codec.
- `sample_ready`, in, 1: response strobe from the sine reader.
- `sample_in`, in, 16: sample from the sine reader; valid while `sample_ready` is high.
- `generate_next`, out, 1: one-cycle request to the sine reader.
- `step_size`, out, 20: step size latched for the current request.
- `sample_out`, out, 16: registered sample delivered to the codec.
- `sample_valid`, out, 1: one-cycle strobe; `sample_out` was updated by a successful pop.
- `fifo_count`, out, clog2(FIFO_DEPTH+1): current occupancy.
- `timeout_err`, out, 1: sticky; set when any request times out.
- `underflow_err`, out, 1: sticky; set when a pop arrives while the FIFO is empty.

## Operation
- The FSM has three states: IDLE, REQ and WAIT. `generate_next` is 1 exactly when the state is REQ.
- IDLE → REQ when `play_enable` is 1 and `fifo_count` < FIFO_DEPTH, evaluated after any same-cycle push or pop.
  - On the same edge, `step_size` ← `step_size_in`.
  - `step_size` holds that value until the next REQ entry.
- REQ → WAIT unconditionally. REQ lasts exactly one cycle. `sample_ready` seen during REQ is ignored.
- In WAIT, the wait counter starts at 0 and increments each cycle.
  - If `sample_ready` is 1: push `sample_in` and go to IDLE.
  - Otherwise, if the counter equals TIMEOUT−1: push 16'd0 (silence), set `timeout_err`, go to IDLE.
- Only one request is outstanding at a time. `sample_ready` seen in IDLE is ignored.
- `play_enable` falling while in REQ or WAIT: the outstanding request completes normally. No further requests are issued. FIFO contents are retained.
- Pop on `codec_next_sample`:
  - FIFO non-empty: `sample_out` ← head, `sample_valid` = 1 on the next cycle, head advances.
  - FIFO empty: `sample_out` ← 16'd0, `sample_valid` stays 0, `underflow_err` is set.
- Simultaneous push and pop:
  - The pop sees the pre-push head. Count is unchanged when the FIFO is non-empty.
  - If the FIFO was empty, the pop underflows and the pushed sample remains, so count becomes 1.
- Push never occurs when the FIFO is full. This is guaranteed because a request is only issued when a slot is free and only one request is outstanding.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Reset values:
  - State IDLE; pointers, counter and `fifo_count` 0.
  - `generate_next` 0, `step_size` 0, `sample_out` 0.
  - `sample_valid` 0, `timeout_err` 0, `underflow_err` 0.
- Reset mid-WAIT: abort to IDLE, discard the response, clear the FIFO.

## Timing
- Request issue: `play_enable` high and FIFO not full at edge t → `generate_next` high during cycle t+1 only.
- Reader response with 2-cycle latency: `sample_ready` high during cycle t+3 → the push lands at edge t+3 and `fifo_count` increments at t+3.
  - At that same edge t+3 the FSM re-evaluates from IDLE (back-to-back). The next `generate_next` is high at t+5.
- Timeout: with no `sample_ready`, WAIT lasts TIMEOUT cycles. Silence is pushed and `timeout_err` rises TIMEOUT+1 cycles after `generate_next`.
- Pop latency: `codec_next_sample` high at edge t → `sample_out` and `sample_valid` are valid in cycle t+1. `sample_valid` is high for exactly one cycle per successful pop.
- Sticky flags clear only on `reset`.

## Test plan
- Reset then fill: `play_enable`=1, `step_size_in`=1000, reader model returns samples 11, 22, 33, 44 with 2-cycle latency.
  - Exactly 4 `generate_next` pulses, each 1 cycle wide, with `step_size`=1000 during each.
  - `fifo_count` reaches 4 and no further requests are issued.
- Drain: 4 pops on the full FIFO → `sample_out` = 11, 22, 33, 44 in order, each with a 1-cycle `sample_valid`.
  - After each pop, a refill request follows.
- Step change mid-request: change `step_size_in` 1500→2000 during WAIT → `step_size` stays 1500 until the next REQ, then becomes 2000.
- Timeout: reader silent → after TIMEOUT=8 WAIT cycles, `timeout_err`=1 and a 0 sample is queued; the next request issues normally.
- Underflow: `play_enable`=0, FIFO empty, pop → `sample_out`=0, no `sample_valid`, `underflow_err`=1.
  - Also pop and push in the same cycle on an empty FIFO → underflow is flagged and `fifo_count`=1.
- Reset during WAIT: assert `reset` 1 cycle after `generate_next`, with a late `sample_ready` of 77 → no push, `fifo_count`=0, all outputs at reset values.

Source files
------------

// File: rtl/sine_sample_fetcher.sv
// Requests samples from the sine reader one at a time and buffers them in a
// small prefetch FIFO that the codec drains one sample per pop pulse.
module sine_sample_fetcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               play_enable,
  input  logic [19:0]                        step_size_in,
  input  logic                               codec_next_sample,
  input  logic                               sample_ready,
  input  logic [15:0]                        sample_in,
  output logic                               generate_next,
  output logic [19:0]                        step_size,
  output logic [15:0]                        sample_out,
  output logic                               sample_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               timeout_err,
  output logic                               underflow_err
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WC_W   = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WC_W-1:0]     r_wait_cnt;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [19:0]         r_step_size;
  logic [DATA_W-1:0]   r_sample_out;
  logic                r_sample_valid;
  logic                r_timeout_err;
  logic                r_underflow_err;

  logic                w_in_wait;
  logic                w_last_wait;
  logic                w_push;
  logic                w_timeout;
  logic                w_pop;
  logic                w_pop_ok;
  logic                w_issue;
  logic [DATA_W-1:0]   w_push_data;

  // A response, or the last allowed WAIT cycle, always produces exactly one push.
  assign w_in_wait   = (r_state == S_WAIT);
  assign w_last_wait = (r_wait_cnt == WC_LAST);
  assign w_push      = w_in_wait && (sample_ready || w_last_wait);
  assign w_timeout   = w_in_wait && !sample_ready && w_last_wait;
  assign w_push_data = sample_ready ? sample_in : '0;
  assign w_pop       = codec_next_sample;
  assign w_pop_ok    = w_pop && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Issue decision looks at occupancy after this edge's push/pop.
  assign w_issue = (r_state == S_IDLE) && play_enable && (w_count_nxt < CNT_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  if (w_push) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    generate_next = (r_state == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_in_wait && !w_push) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_size <= '0;
    end else if (w_issue) begin
      r_step_size <= step_size_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // An empty pop reads silence so the codec never replays a stale sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_sample_out <= r_mem[r_rd_ptr];
      end else if (w_pop) begin
        r_sample_out <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_err   <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (w_timeout)           r_timeout_err   <= 1'b1;
      if (w_pop && !w_pop_ok)  r_underflow_err <= 1'b1;
    end
  end

  assign step_size     = r_step_size;
  assign sample_out    = r_sample_out;
  assign sample_valid  = r_sample_valid;
  assign fifo_count    = r_count;
  assign timeout_err   = r_timeout_err;
  assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_sine_sample_fetcher.sv
// Directed bench for sine_sample_fetcher with a 2-cycle-latency sine reader model.
module tb_sine_sample_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic [19:0] step_size_in;
  logic        codec_next_sample;
  logic        sample_ready;
  logic [15:0] sample_in;
  logic        generate_next;
  logic [19:0] step_size;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [2:0]  fifo_count;
  logic        timeout_err;
  logic        underflow_err;

  int errors = 0;
  int checks = 0;
  int gn_total = 0;

  logic [15:0] resp_q[$];
  bit          resp_en = 1'b1;
  int          dly = 0;

  sine_sample_fetcher #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .play_enable       (play_enable),
    .step_size_in      (step_size_in),
    .codec_next_sample (codec_next_sample),
    .sample_ready      (sample_ready),
    .sample_in         (sample_in),
    .generate_next     (generate_next),
    .step_size         (step_size),
    .sample_out        (sample_out),
    .sample_valid      (sample_valid),
    .fifo_count        (fifo_count),
    .timeout_err       (timeout_err),
    .underflow_err     (underflow_err)
  );

  always #5 clk = ~clk;

  // Reader model: request seen in cycle g, response strobe during cycle g+2.
  initial begin
    sample_ready = 1'b0;
    sample_in    = 16'd0;
    forever begin
      @(negedge clk);
      sample_ready = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          sample_ready = 1'b1;
          if (resp_q.size() > 0) sample_in = resp_q.pop_front();
          else                   sample_in = 16'hBEEF;
        end
      end
      if (generate_next && resp_en) dly = 2;
      if (generate_next) gn_total++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic wait_gn(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (generate_next) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; play_enable = 1'b0; codec_next_sample = 1'b0; step_size_in = 20'd0;
    repeat (3) @(negedge clk);
    checks++; if (generate_next !== 1'b0) begin errors++; $display("FAIL rst_gn got=%0b exp=0", generate_next); end
    checks++; if (step_size !== 20'd0) begin errors++; $display("FAIL rst_step got=%0d exp=0", step_size); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL rst_sample_out got=%0d exp=0", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", sample_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%0b exp=0", timeout_err); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL rst_underflow got=%0b exp=0", underflow_err); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (generate_next !== 1'b0) begin errors++; $display("FAIL idle_no_gn got=%0b exp=0", generate_next); end
  endtask

  task automatic test_fill();
    int n, wide, bad;
    bit prev;
    resp_q = '{16'd11, 16'd22, 16'd33, 16'd44};
    step_size_in = 20'd1000;
    play_enable  = 1'b1;
    @(negedge clk);
    checks++; if (generate_next !== 1'b1) begin errors++; $display("FAIL fill_first_gn got=%0b exp=1", generate_next); end
    checks++; if (step_size !== 20'd1000) begin errors++; $display("FAIL fill_first_step got=%0d exp=1000", step_size); end
    @(negedge clk);
    checks++; if (generate_next !== 1'b0) begin errors++; $display("FAIL fill_gn_width got=%0b exp=0", generate_next); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL fill_count1 got=%0d exp=1", fifo_count); end
    @(negedge clk);
    checks++; if (generate_next !== 1'b1) begin errors++; $display("FAIL fill_b2b_gn got=%0b exp=1", generate_next); end
    n = 2; wide = 0; bad = 0; prev = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (generate_next) begin
        n++;
        if (prev) wide++;
        if (step_size !== 20'd1000) bad++;
      end
      prev = generate_next;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL fill_gn_pulses got=%0d exp=4", n); end
    checks++; if (wide !== 0) begin errors++; $display("FAIL fill_wide_pulses got=%0d exp=0", wide); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_step_during_gn got=%0d bad exp=0", bad); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_full got=%0d exp=4", fifo_count); end
  endtask

  task automatic test_drain();
    logic [15:0] exp_d [4];
    int gn0;
    exp_d = '{16'd11, 16'd22, 16'd33, 16'd44};
    resp_q = '{16'd55, 16'd66, 16'd77, 16'd88};
    gn0 = gn_total;
    for (int i = 0; i < 4; i++) begin
      codec_next_sample = 1'b1;
      @(negedge clk);
      codec_next_sample = 1'b0;
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, sample_valid); end
      checks++; if (sample_out !== exp_d[i]) begin errors++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", i, sample_out, exp_d[i]); end
      if (i == 0) begin
        checks++; if (generate_next !== 1'b1) begin errors++; $display("FAIL drain_refill_gn got=%0b exp=1", generate_next); end
      end
      @(negedge clk);
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_width[%0d] got=%0b exp=0", i, sample_valid); end
    end
    repeat (20) @(negedge clk);
    checks++; if (gn_total - gn0 !== 4) begin errors++; $display("FAIL drain_refills got=%0d exp=4", gn_total - gn0); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL drain_refull got=%0d exp=4", fifo_count); end
  endtask

  task automatic test_wrap_drain();
    logic [15:0] exp_d [4];
    int gn0;
    exp_d = '{16'd55, 16'd66, 16'd77, 16'd88};
    play_enable = 1'b0;
    gn0 = gn_total;
    for (int i = 0; i < 4; i++) begin
      codec_next_sample = 1'b1;
      @(negedge clk);
      codec_next_sample = 1'b0;
      checks++; if (sample_out !== exp_d[i]) begin errors++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", i, sample_out, exp_d[i]); end
      @(negedge clk);
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL wrap_empty got=%0d exp=0", fifo_count); end
    checks++; if (gn_total !== gn0) begin errors++; $display("FAIL wrap_no_req got=%0d exp=%0d", gn_total, gn0); end
  endtask

  task automatic test_step_change();
    bit ok;
    step_size_in = 20'd1500;
    resp_q = '{16'd101, 16'd102};
    play_enable = 1'b1;
    @(negedge clk);
    checks++; if (generate_next !== 1'b1 || step_size !== 20'd1500) begin errors++; $display("FAIL step_req1 got=%0b/%0d exp=1/1500", generate_next, step_size); end
    @(negedge clk);
    step_size_in = 20'd2000;
    @(negedge clk);
    checks++; if (step_size !== 20'd1500) begin errors++; $display("FAIL step_hold got=%0d exp=1500", step_size); end
    wait_gn(10, ok);
    play_enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL step_req2_wait got=none exp=generate_next"); end
    checks++; if (step_size !== 20'd2000) begin errors++; $display("FAIL step_new got=%0d exp=2000", step_size); end
    repeat (6) @(negedge clk);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL step_count got=%0d exp=2", fifo_count); end
  endtask

  task automatic test_timeout();
    logic [15:0] exp_d [4];
    exp_d = '{16'd101, 16'd102, 16'd0, 16'd123};
    resp_en = 1'b0;
    play_enable = 1'b1;
    @(negedge clk);
    play_enable = 1'b0;
    checks++; if (generate_next !== 1'b1) begin errors++; $display("FAIL to_gn got=%0b exp=1", generate_next); end
    repeat (8) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got=%0b exp=0", timeout_err); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got=%0b exp=1", timeout_err); end
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL to_count got=%0d exp=3", fifo_count); end
    resp_en = 1'b1;
    resp_q = '{16'd123};
    play_enable = 1'b1;
    @(negedge clk);
    play_enable = 1'b0;
    checks++; if (generate_next !== 1'b1) begin errors++; $display("FAIL to_next_gn got=%0b exp=1", generate_next); end
    repeat (4) @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL to_next_count got=%0d exp=4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      codec_next_sample = 1'b1;
      @(negedge clk);
      codec_next_sample = 1'b0;
      checks++; if (sample_out !== exp_d[i]) begin errors++; $display("FAIL to_data[%0d] got=%0d exp=%0d", i, sample_out, exp_d[i]); end
      @(negedge clk);
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%0b exp=1", timeout_err); end
  endtask

  task automatic test_underflow();
    codec_next_sample = 1'b1;
    @(negedge clk);
    codec_next_sample = 1'b0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL uf_valid got=%0b exp=0", sample_valid); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL uf_data got=%0d exp=0", sample_out); end
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_flag got=%0b exp=1", underflow_err); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (underflow_err !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL uf_clear got=%0b/%0b exp=0/0", underflow_err, timeout_err); end
    resp_q = '{16'd200};
    play_enable = 1'b1;
    @(negedge clk);
    play_enable = 1'b0;
    checks++; if (generate_next !== 1'b1) begin errors++; $display("FAIL uf_gn got=%0b exp=1", generate_next); end
    @(negedge clk);
    @(negedge clk);
    codec_next_sample = 1'b1;
    @(negedge clk);
    codec_next_sample = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL uf_pushpop_count got=%0d exp=1", fifo_count); end
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_pushpop_flag got=%0b exp=1", underflow_err); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL uf_pushpop_valid got=%0b exp=0", sample_valid); end
    codec_next_sample = 1'b1;
    @(negedge clk);
    codec_next_sample = 1'b0;
    checks++; if (sample_valid !== 1'b1 || sample_out !== 16'd200) begin errors++; $display("FAIL uf_kept got=%0b/%0d exp=1/200", sample_valid, sample_out); end
  endtask

  task automatic test_reset_wait();
    bit ok1, ok2;
    step_size_in = 20'd3000;
    resp_q = '{16'd150, 16'd77};
    play_enable = 1'b1;
    wait_gn(5, ok1);
    wait_gn(10, ok2);
    play_enable = 1'b0;
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL rw_gn got=%0b%0b exp=11", ok1, ok2); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rw_pre_count got=%0d exp=1", fifo_count); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rw_count got=%0d exp=0", fifo_count); end
    checks++; if (step_size !== 20'd0) begin errors++; $display("FAIL rw_step got=%0d exp=0", step_size); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL rw_sample_out got=%0d exp=0", sample_out); end
    checks++; if (generate_next !== 1'b0 || sample_valid !== 1'b0) begin errors++; $display("FAIL rw_strobes got=%0b/%0b exp=0/0", generate_next, sample_valid); end
    checks++; if (timeout_err !== 1'b0 || underflow_err !== 1'b0) begin errors++; $display("FAIL rw_flags got=%0b/%0b exp=0/0", timeout_err, underflow_err); end
    repeat (3) @(negedge clk);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rw_late_push got=%0d exp=0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap_drain();
    test_step_change();
    test_timeout();
    test_underflow();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
